flow_ctl_unit: RTL and testbench
================================

Name: flow_ctl_unit

Overview:
Registered decode-stage flow-control unit for the pipelined MIPS core. It decodes j, jal, jr, jalr, beq and bne, and computes jump and branch targets. It tracks one outstanding conditional branch until the execute stage resolves it. On every control-flow change it issues a one-cycle redirect to fetch and squashes a configurable number of wrong-path instructions already in flight.

Parameters:
WIDTH, 32, instruction/PC datapath width (must be ≥32; opcode at [31:26], funct at [5:0]).
SQUASH_SLOTS, 1, wrong-path beats dropped after a redirect; 0 = architectural delay-slot semantics (nothing dropped).
CNT_W, 3, squash counter width; SQUASH_SLOTS < 2**CNT_W.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
cmdIn  in  WIDTH  fetched instruction
pcIn  in  WIDTH  PC of cmdIn
stall  in  1  downstream hold; freezes stage register and squash counter
brResolve  in  1  execute-stage resolution strobe for the pending branch
brTaken  in  1  resolution outcome, qualified by brResolve
out_valid  out  1  registered beat valid
cmdOut  out  WIDTH  registered instruction, unmodified
isJmp  out  1  j or jal
isJr  out  1  jr or jalr
isBr  out  1  beq or bne
isLink  out  1  jal or jalr
target  out  WIDTH  computed target (0 for jr/jalr and non-flow instructions)
redirect  out  1  one-cycle fetch redirect pulse
redirectPc  out  WIDTH  redirect destination, valid while redirect=1
brPending  out  1  a branch is awaiting resolution

Behaviour:
- Reset (sync, dominates all inputs): out_valid=0, all is* flags=0, cmdOut=0, target=0, redirect=0, redirectPc=0, brPending=0, squash count=0, state=IDLE.
- Decode: j op=0x02; jal 0x03; jr op=0x00 & funct=0x08; jalr op=0x00 & funct=0x09; beq 0x04; bne 0x05.
- Jump target: {pc4[WIDTH-1:28], cmd[25:0], 2'b00}.
- Branch target: pc4 + (sext(cmd[15:0]) << 2), mod 2**WIDTH with wrap allowed.
- pc4 = pcIn + 4.
- in_ready = !stall & !(state==BR_WAIT & incoming beat is j/jal/beq/bne). Non-flow and jr/jalr beats pass while BR_WAIT.
- Latency: an accepted beat appears on out_valid and the decoded outputs exactly 1 cycle later.
- With stall=1, all registered outputs hold, except that redirect always self-clears after one cycle.
- Squash: an accepted beat that arrives while the count is >0 is dropped. out_valid=0 on the next cycle and the count decrements by 1. Cycles with no accepted beat leave the count unchanged.
- FSM states:
  - IDLE: an accepted, non-squashed j/jal registers redirect=1 and redirectPc=target in the same cycle that out_valid rises, and loads count=SQUASH_SLOTS. An accepted beq/bne moves to BR_WAIT and latches its target; brPending=1 from the next cycle.
  - BR_WAIT: on brResolve with brTaken=1, the next cycle has redirect=1, redirectPc=latched target, count=SQUASH_SLOTS, state=IDLE. On brResolve with brTaken=0, return to IDLE with no redirect. brPending clears the cycle after brResolve.
  - brResolve is sampled even when stall=1. brResolve in IDLE is ignored.
- Simultaneous events:
  - Resolution and a new accepted beat in the same cycle: the beat is decoded under the pre-resolution count.
  - Taken resolution while the count is non-zero: the count reloads to SQUASH_SLOTS.
  - Squashed j/beq beats never redirect or enter BR_WAIT.
- Reset mid-BR_WAIT or mid-squash discards the pending branch and the count. No redirect is emitted.
- jr/jalr never redirect from this block; the register target is resolved downstream.

Decomposition:
- Shared package flow_pkg: opcode/funct constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, FN_JR, FN_JALR) and the state enum {IDLE, BR_WAIT}.
- One sub-module: flow_decode. It is purely combinational and produces the is* flags and target from cmdIn and pcIn. The parent holds the stage register, FSM and squash counter.

Test Plan:
1. j at pcIn=0x00400010, cmdIn=0x08100008, SQUASH_SLOTS=1 -> next cycle out_valid=1, isJmp=1, target=redirectPc=0x00400020, redirect=1 for one cycle; the next accepted beat is dropped (out_valid=0).
2. beq at pcIn=0x00400000, cmdIn=0x10000003 -> target=0x00400010, brPending=1. Two brResolve=1, brTaken=1 follows -> redirect=1, redirectPc=0x00400010 the next cycle, brPending=0.
3. bne at pcIn=0x00000100, cmdIn=0x1400FFFF -> target=0x00000100. brResolve with brTaken=0 -> no redirect, state IDLE, next beat not squashed.
4. While BR_WAIT, present j (0x08000000) -> in_ready=0 until the cycle after brResolve. An add (0x00221820) presented during BR_WAIT is accepted.
5. SQUASH_SLOTS=0: j followed by an add -> the add emerges with out_valid=1 (delay slot kept).
6. Assert reset in BR_WAIT with stall=1, then brResolve=1, brTaken=1 -> all outputs 0 after reset, no redirect.

Source files
------------

// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - opcode/funct constants and FSM state type for the decode-stage flow-control unit
package flow_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic {
    IDLE    = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/flow_decode.sv
// rtl/flow_decode.sv - combinational control-flow decode and target computation
//
// Ports:
//   cmd     in   fetched instruction
//   pc      in   PC of cmd
//   is_jmp  out  j or jal
//   is_jr   out  jr or jalr
//   is_br   out  beq or bne
//   is_link out  jal or jalr
//   target  out  jump/branch target, 0 for jr/jalr and non-flow instructions
module flow_decode
  import flow_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] cmd,
  input  logic [WIDTH-1:0] pc,
  output logic             is_jmp,
  output logic             is_jr,
  output logic             is_br,
  output logic             is_link,
  output logic [WIDTH-1:0] target
);

  logic [5:0]       op;
  logic [5:0]       fn;
  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] jmp_tgt;
  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_tgt;

  assign op      = cmd[31:26];
  assign fn      = cmd[5:0];
  assign pc4     = pc + WIDTH'(4);
  assign jmp_tgt = {pc4[WIDTH-1:28], cmd[25:0], 2'b00};
  assign br_off  = {{(WIDTH-18){cmd[15]}}, cmd[15:0], 2'b00};
  assign br_tgt  = pc4 + br_off;  // wraps modulo 2**WIDTH

  always_comb begin
    is_jmp  = 1'b0;
    is_jr   = 1'b0;
    is_br   = 1'b0;
    is_link = 1'b0;
    target  = '0;
    case (op)
      OP_J: begin
        is_jmp = 1'b1;
        target = jmp_tgt;
      end
      OP_JAL: begin
        is_jmp  = 1'b1;
        is_link = 1'b1;
        target  = jmp_tgt;
      end
      OP_BEQ, OP_BNE: begin
        is_br  = 1'b1;
        target = br_tgt;
      end
      OP_RTYPE: begin
        // register-indirect targets are resolved downstream, so target stays 0
        if (fn == FN_JR) begin
          is_jr = 1'b1;
        end else if (fn == FN_JALR) begin
          is_jr   = 1'b1;
          is_link = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/flow_ctl_unit.sv
// rtl/flow_ctl_unit.sv - registered decode-stage flow control: redirects, branch tracking, wrong-path squash
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     fetch beat handshake; cmdIn/pcIn carry the beat
//   stall                 downstream hold for the stage register and squash counter
//   brResolve/brTaken     execute-stage resolution of the pending branch
//   out_valid, cmdOut     registered beat and instruction
//   isJmp/isJr/isBr/isLink/target  registered decode results
//   redirect/redirectPc   one-cycle fetch redirect pulse and destination
//   brPending             a branch is awaiting resolution
module flow_ctl_unit
  import flow_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SQUASH_SLOTS = 1,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] cmdIn,
  input  logic [WIDTH-1:0] pcIn,
  input  logic             stall,
  input  logic             brResolve,
  input  logic             brTaken,
  output logic             out_valid,
  output logic [WIDTH-1:0] cmdOut,
  output logic             isJmp,
  output logic             isJr,
  output logic             isBr,
  output logic             isLink,
  output logic [WIDTH-1:0] target,
  output logic             redirect,
  output logic [WIDTH-1:0] redirectPc,
  output logic             brPending
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SQUASH_SLOTS);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] br_tgt;
  logic             latch_br;
  logic             accept;
  logic             drop;
  logic             keep;
  logic             redirect_nxt;
  logic [WIDTH-1:0] redirect_pc_nxt;

  logic             d_jmp;
  logic             d_jr;
  logic             d_br;
  logic             d_link;
  logic [WIDTH-1:0] d_tgt;

  flow_decode #(.WIDTH(WIDTH)) u_decode (
    .cmd     (cmdIn),
    .pc      (pcIn),
    .is_jmp  (d_jmp),
    .is_jr   (d_jr),
    .is_br   (d_br),
    .is_link (d_link),
    .target  (d_tgt)
  );

  assign brPending = (state == BR_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    redirect_nxt    = 1'b0;
    redirect_pc_nxt = redirectPc;
    latch_br        = 1'b0;
    // only one branch may be outstanding, and a jump behind it would be on
    // a possibly wrong path, so both are held off until resolution
    in_ready        = !stall && !((state == BR_WAIT) && (d_jmp || d_br));
    accept          = in_valid && in_ready;
    drop            = accept && (cnt != '0);
    keep            = accept && !drop;
    if (drop) begin
      cnt_nxt = cnt - 1'b1;
    end
    case (state)
      IDLE: begin
        if (keep && d_jmp) begin
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = d_tgt;
          cnt_nxt         = RELOAD;
        end else if (keep && d_br) begin
          state_nxt = BR_WAIT;
          latch_br  = 1'b1;
        end
      end
      BR_WAIT: begin
        // resolution is honoured even under stall; a taken outcome overrides
        // any squash still in progress
        if (brResolve) begin
          state_nxt = IDLE;
          if (brTaken) begin
            redirect_nxt    = 1'b1;
            redirect_pc_nxt = br_tgt;
            cnt_nxt         = RELOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      cmdOut     <= '0;
      isJmp      <= 1'b0;
      isJr       <= 1'b0;
      isBr       <= 1'b0;
      isLink     <= 1'b0;
      target     <= '0;
      redirect   <= 1'b0;
      redirectPc <= '0;
      cnt        <= '0;
      br_tgt     <= '0;
    end else begin
      redirect   <= redirect_nxt;
      redirectPc <= redirect_pc_nxt;
      cnt        <= cnt_nxt;
      if (latch_br) begin
        br_tgt <= d_tgt;
      end
      if (!stall) begin
        out_valid <= keep;
        if (keep) begin
          cmdOut <= cmdIn;
          isJmp  <= d_jmp;
          isJr   <= d_jr;
          isBr   <= d_br;
          isLink <= d_link;
          target <= d_tgt;
        end
      end
    end
  end

endmodule

// File: tb/tb_flow_ctl_unit.sv
// tb/tb_flow_ctl_unit.sv - self-checking bench for flow_ctl_unit with three squash depths
module tb_flow_ctl_unit;

  localparam logic [31:0] ADD = 32'h00221820;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, brResolve, brTaken;
  logic [31:0] cmdIn, pcIn;

  logic        rdy [3];
  logic        ov  [3];
  logic        jmp [3];
  logic        jr  [3];
  logic        br  [3];
  logic        lnk [3];
  logic        rd  [3];
  logic        pend[3];
  logic [31:0] co  [3];
  logic [31:0] tg  [3];
  logic [31:0] rpc [3];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // instance 0: SQUASH_SLOTS=1, instance 1: 0 (delay slot), instance 2: 2
  for (genvar g = 0; g < 3; g++) begin : g_dut
    flow_ctl_unit #(
      .WIDTH(32),
      .SQUASH_SLOTS((g == 0) ? 1 : ((g == 1) ? 0 : 2)),
      .CNT_W(3)
    ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[g]),
      .cmdIn(cmdIn), .pcIn(pcIn), .stall(stall),
      .brResolve(brResolve), .brTaken(brTaken),
      .out_valid(ov[g]), .cmdOut(co[g]), .isJmp(jmp[g]), .isJr(jr[g]),
      .isBr(br[g]), .isLink(lnk[g]), .target(tg[g]),
      .redirect(rd[g]), .redirectPc(rpc[g]), .brPending(pend[g])
    );
  end

  // ---------------- reference model ----------------
  int          m_cnt  [3];
  logic        m_pend [3];
  logic [31:0] m_btgt [3];
  logic        e_ov[3], e_jmp[3], e_jr[3], e_br[3], e_lnk[3], e_rd[3];
  logic [31:0] e_co[3], e_tg[3], e_rpc[3];

  function automatic int slots_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
  endfunction

  // 0 other, 1 j, 2 jal, 3 jr, 4 jalr, 5 beq, 6 bne
  function automatic int kind(logic [31:0] c);
    int op, fn;
    op = int'(c[31:26]);
    fn = int'(c[5:0]);
    if (op == 2) return 1;
    if (op == 3) return 2;
    if (op == 4) return 5;
    if (op == 5) return 6;
    if (op == 0 && fn == 8) return 3;
    if (op == 0 && fn == 9) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] mtarget(int kd, logic [31:0] c, logic [31:0] p);
    int off;
    if (kd == 1 || kd == 2)
      return ((p + 32'd4) & 32'hF000_0000) | ((c & 32'h03FF_FFFF) * 32'd4);
    if (kd == 5 || kd == 6) begin
      off = int'($signed(c[15:0]));
      return p + 32'd4 + 32'(off * 4);
    end
    return 32'd0;
  endfunction

  function automatic logic m_rdy(int k);
    int kd;
    kd = kind(cmdIn);
    return !stall && !(m_pend[k] && (kd == 1 || kd == 2 || kd == 5 || kd == 6));
  endfunction

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int   kd;
      logic acc, dr, kp, isj, isb;
      if (reset) begin
        m_cnt[k] = 0; m_pend[k] = 1'b0; m_btgt[k] = '0;
        e_ov[k] = 1'b0; e_jmp[k] = 1'b0; e_jr[k] = 1'b0; e_br[k] = 1'b0;
        e_lnk[k] = 1'b0; e_rd[k] = 1'b0; e_co[k] = '0; e_tg[k] = '0; e_rpc[k] = '0;
        continue;
      end
      kd  = kind(cmdIn);
      isj = (kd == 1 || kd == 2);
      isb = (kd == 5 || kd == 6);
      acc = in_valid && m_rdy(k);
      dr  = acc && (m_cnt[k] > 0);
      kp  = acc && !dr;
      e_rd[k] = 1'b0;
      if (!stall) begin
        e_ov[k] = kp;
        if (kp) begin
          e_co[k]  = cmdIn;
          e_jmp[k] = isj;
          e_jr[k]  = (kd == 3 || kd == 4);
          e_br[k]  = isb;
          e_lnk[k] = (kd == 2 || kd == 4);
          e_tg[k]  = mtarget(kd, cmdIn, pcIn);
        end
      end
      if (dr) m_cnt[k]--;
      if (kp && isj) begin
        e_rd[k]  = 1'b1;
        e_rpc[k] = mtarget(kd, cmdIn, pcIn);
        m_cnt[k] = slots_of(k);
      end
      if (m_pend[k] && brResolve) begin
        m_pend[k] = 1'b0;
        if (brTaken) begin
          e_rd[k]  = 1'b1;
          e_rpc[k] = m_btgt[k];
          m_cnt[k] = slots_of(k);
        end
      end else if (kp && isb) begin
        m_pend[k] = 1'b1;
        m_btgt[k] = mtarget(kd, cmdIn, pcIn);
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] c, input logic [31:0] p,
                       input logic s = 1'b0, input logic r = 1'b0, input logic t = 1'b0,
                       input logic rs = 1'b0);
    in_valid = v; cmdIn = c; pcIn = p; stall = s; brResolve = r; brTaken = t; reset = rs;
  endtask

  task automatic step();
    #1;
    for (int k = 0; k < 3; k++) chk("in_ready", k, 32'(rdy[k]), 32'(m_rdy(k)));
    @(posedge clk);
    model_update();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("out_valid", k, 32'(ov[k]), 32'(e_ov[k]));
      chk("redirect", k, 32'(rd[k]), 32'(e_rd[k]));
      chk("brPending", k, 32'(pend[k]), 32'(m_pend[k]));
      chk("redirectPc", k, rpc[k], e_rpc[k]);
      chk("cmdOut", k, co[k], e_co[k]);
      chk("target", k, tg[k], e_tg[k]);
      chk("flags", k, {28'd0, jmp[k], jr[k], br[k], lnk[k]},
          {28'd0, e_jmp[k], e_jr[k], e_br[k], e_lnk[k]});
    end
  endtask

  initial begin
    logic [31:0] c, p;
    int sel;

    // reset state
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1); step();
    chk("rst_ov", 0, 32'(ov[0]), 32'd0);
    chk("rst_rd", 0, 32'(rd[0]), 32'd0);
    chk("rst_pend", 0, 32'(pend[0]), 32'd0);
    chk("rst_cmd", 0, co[0], 32'd0);
    chk("rst_tgt", 0, tg[0], 32'd0);
    chk("rst_rpc", 0, rpc[0], 32'd0);

    // j with one squash slot, then the wrong-path beat
    drive(1'b1, 32'h08100008, 32'h00400010); step();
    chk("j_ov", 0, 32'(ov[0]), 32'd1);
    chk("j_isJmp", 0, 32'(jmp[0]), 32'd1);
    chk("j_tgt", 0, tg[0], 32'h00400020);
    chk("j_rd", 0, 32'(rd[0]), 32'd1);
    chk("j_rpc", 0, rpc[0], 32'h00400020);
    drive(1'b1, ADD, 32'h00400014); step();
    chk("j_rd_clr", 0, 32'(rd[0]), 32'd0);
    chk("j_squash", 0, 32'(ov[0]), 32'd0);
    chk("dslot_ov", 1, 32'(ov[1]), 32'd1);
    chk("dslot_cmd", 1, co[1], ADD);
    drive(1'b0, 32'd0, 32'd0); step();

    // beq taken
    drive(1'b1, 32'h10000003, 32'h00400000); step();
    chk("beq_tgt", 0, tg[0], 32'h00400010);
    chk("beq_isBr", 0, 32'(br[0]), 32'd1);
    chk("beq_pend", 0, 32'(pend[0]), 32'd1);
    drive(1'b0, 32'd0, 32'd0); step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1); step();
    chk("beq_rd", 0, 32'(rd[0]), 32'd1);
    chk("beq_rpc", 0, rpc[0], 32'h00400010);
    chk("beq_pend_clr", 0, 32'(pend[0]), 32'd0);
    drive(1'b1, ADD, 32'h00400010); step();
    chk("beq_squash", 0, 32'(ov[0]), 32'd0);

    // bne backwards, not taken
    drive(1'b1, 32'h1400FFFF, 32'h00000100); step();
    chk("bne_tgt", 0, tg[0], 32'h00000100);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0); step();
    chk("bne_no_rd", 0, 32'(rd[0]), 32'd0);
    chk("bne_pend_clr", 0, 32'(pend[0]), 32'd0);
    drive(1'b1, ADD, 32'h00000104); step();
    chk("bne_no_squash", 0, 32'(ov[0]), 32'd1);

    // backpressure of jumps during BR_WAIT
    drive(1'b1, 32'h10000003, 32'h00000200); step();
    drive(1'b1, 32'h08000000, 32'h00000204); #1;
    chk("bw_j_rdy", 0, 32'(rdy[0]), 32'd0);
    step();
    chk("bw_j_ov", 0, 32'(ov[0]), 32'd0);
    drive(1'b1, ADD, 32'h00000204); #1;
    chk("bw_add_rdy", 0, 32'(rdy[0]), 32'd1);
    step();
    chk("bw_add_ov", 0, 32'(ov[0]), 32'd1);
    drive(1'b1, 32'h08000000, 32'h00000208, 1'b0, 1'b1, 1'b0); #1;
    chk("bw_res_rdy", 0, 32'(rdy[0]), 32'd0);
    step();
    drive(1'b1, 32'h08000000, 32'h00000208); #1;
    chk("bw_after_rdy", 0, 32'(rdy[0]), 32'd1);
    step();
    chk("bw_after_rd", 0, 32'(rd[0]), 32'd1);

    // reset during BR_WAIT with stall, then a late resolution
    drive(1'b1, ADD, 32'h0000020C); step();
    drive(1'b1, 32'h10000003, 32'h00000300); step();
    chk("rb_pend", 0, 32'(pend[0]), 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1); step();
    chk("rb_rd", 0, 32'(rd[0]), 32'd0);
    chk("rb_pend_clr", 0, 32'(pend[0]), 32'd0);
    chk("rb_ov", 0, 32'(ov[0]), 32'd0);
    chk("rb_rpc", 0, rpc[0], 32'd0);

    // randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       c = {6'h02, 26'($urandom)};
        1:       c = {6'h03, 26'($urandom)};
        2:       c = {6'h00, 20'($urandom), 6'h08};
        3:       c = {6'h00, 20'($urandom), 6'h09};
        4:       c = {6'h04, 26'($urandom)};
        5:       c = {6'h05, 26'($urandom)};
        6:       c = ADD;
        default: c = $urandom;
      endcase
      p = $urandom;
      p[1:0] = 2'b00;
      drive(1'($urandom_range(0, 3) != 0), c, p,
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
